sys_clkgen: RTL and testbench

SYS_CLKGEN -- requirements
Module: sys_clkgen

---
 rtl/sys1_clk_pkg.sv | 33 +++
 rtl/ce_div.sv | 59 +++++
 rtl/sys_clkgen.sv | 192 +++++++++++++++++++
 tb/tb_sys_clkgen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys1_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sys1_clk_pkg
//  Purpose  : Shared definitions for the system clock-enable generator:
//             FSM state encoding, default divisor/timing constants and a
//             counter-width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sys1_clk_pkg;

    // Reset/lock sequencing states
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,   // waiting for a synchronized PLL lock
        ST_STAB = 2'd1,   // lock must remain stable for LOCK_WAIT cycles
        ST_HOLD = 2'd2,   // enables running, core reset still asserted
        ST_RUN  = 2'd3    // normal operation
    } clk_state_t;

    // Default timing / divisor values (49.147727 MHz system clock)
    localparam int unsigned c_lock_wait_def = 4096;
    localparam int unsigned c_rst_hold_def  = 64;
    localparam int unsigned c_pix_div_def   = 8;    // 6.14 MHz pixel enable
    localparam int unsigned c_cpu_div_def   = 12;   // 4.096 MHz CPU enable
    localparam int unsigned c_psg_div_x_def = 2;    // 2.048 MHz PSG enable

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ce_div.sv
`default_nettype none
// ============================================================================
//  Module   : ce_div
//  Purpose  : Modulo-DIV counter producing a registered one-cycle clock
//             enable. The counter advances on i_advance and wraps at DIV-1;
//             o_ce is high for the cycle after the wrap, qualified by i_gate.
//             o_wrap is the combinational wrap strobe, used to cascade a
//             further divider that must fire on the same edge.
//  Ports    : clk       in   system clock
//             rst_n     in   asynchronous active-low reset
//             i_clear   in   synchronous clear of counter and enable
//             i_advance in   count enable
//             i_gate    in   enable output qualifier (counter unaffected)
//             o_ce      out  registered one-cycle clock enable
//             o_wrap    out  combinational terminal-count strobe
//  Revision : 1.0 - initial release
// ============================================================================
module ce_div
    import sys1_clk_pkg::*;
#(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_advance,
    input  logic i_gate,
    output logic o_ce,
    output logic o_wrap
);

    localparam int unsigned   c_w    = cnt_width(DIV);
    localparam logic [c_w-1:0] c_last = c_w'(DIV - 1);
    localparam logic [c_w-1:0] c_one  = c_w'(1);

    logic [c_w-1:0] r_cnt;
    logic           w_wrap;

    assign w_wrap = i_advance && (r_cnt == c_last);
    assign o_wrap = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            o_ce  <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            o_ce  <= 1'b0;
        end else begin
            if (i_advance) begin
                r_cnt <= (r_cnt == c_last) ? '0 : (r_cnt + c_one);
            end
            // Gate only the output so the counting grid survives a pause.
            o_ce <= w_wrap && i_gate;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_clkgen.sv
`default_nettype none
// ============================================================================
//  Module   : sys_clkgen
//  Purpose  : System reset sequencer and clock-enable generator. Waits for a
//             stable PLL lock, holds the core in reset for RST_HOLD cycles
//             while the enables already run, then releases reset. Generates
//             pixel, CPU and PSG clock enables from the system clock.
//  Ports    : clk        in   system clock (PLL output)
//             rst_n      in   asynchronous active-low reset
//             pll_locked in   PLL lock flag, asynchronous to clk
//             reset_req  in   soft-reset request, level
//             pause      in   suppresses ce_cpu / ce_psg
//             sys_rst    out  registered active-high core reset
//             ce_pix     out  pixel clock enable
//             ce_cpu     out  CPU clock enable
//             ce_psg     out  PSG clock enable
//             running    out  high in state RUN
//  Revision : 1.0 - initial release
// ============================================================================
module sys_clkgen
    import sys1_clk_pkg::*;
#(
    parameter int unsigned LOCK_WAIT = c_lock_wait_def,
    parameter int unsigned RST_HOLD  = c_rst_hold_def,
    parameter int unsigned PIX_DIV   = c_pix_div_def,
    parameter int unsigned CPU_DIV   = c_cpu_div_def,
    parameter int unsigned PSG_DIV_X = c_psg_div_x_def
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic reset_req,
    input  logic pause,
    output logic sys_rst,
    output logic ce_pix,
    output logic ce_cpu,
    output logic ce_psg,
    output logic running
);

    localparam int unsigned c_cnt_max = (LOCK_WAIT > RST_HOLD) ? LOCK_WAIT : RST_HOLD;
    localparam int unsigned c_cnt_w   = cnt_width(c_cnt_max);
    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(RST_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= pll_locked;
            r_locked_s <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    clk_state_t           r_state;
    clk_state_t           w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
            sys_rst <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Reset follows next-state so it drops on the edge entering RUN
            // and rises on the edge leaving it.
            sys_rst <= (w_state_next != ST_RUN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_WAIT: begin
                w_cnt_next = '0;
                if (r_locked_s) begin
                    w_state_next = ST_STAB;
                end
            end
            ST_STAB: begin
                if (!r_locked_s) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_lock_last) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            ST_HOLD: begin
                if (!r_locked_s) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = '0;
                end else if (reset_req) begin
                    w_cnt_next = '0;           // restart the hold window
                end else if (r_cnt == c_hold_last) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            ST_RUN: begin
                if (!r_locked_s) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = '0;
                end else if (reset_req) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_WAIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign running = (r_state == ST_RUN);

    // ------------------------------------------------------------------
    // Clock-enable dividers
    // ------------------------------------------------------------------
    // Dividers run only in HOLD/RUN and restart on every HOLD entry, so the
    // enable phase relative to reset release is the same after every reset.
    logic w_active;
    logic w_hold_entry;
    logic w_div_clear;
    logic w_cpu_wrap;
    logic w_pix_wrap_unused;
    logic w_psg_wrap_unused;

    assign w_active     = (w_state_next == ST_HOLD) || (w_state_next == ST_RUN);
    assign w_hold_entry = (w_state_next == ST_HOLD) && (r_state != ST_HOLD);
    assign w_div_clear  = !w_active || w_hold_entry;

    ce_div #(
        .DIV       (PIX_DIV)
    ) u_pix_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_div_clear),
        .i_advance (1'b1),
        .i_gate    (1'b1),
        .o_ce      (ce_pix),
        .o_wrap    (w_pix_wrap_unused)
    );

    ce_div #(
        .DIV       (CPU_DIV)
    ) u_cpu_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_div_clear),
        .i_advance (1'b1),
        .i_gate    (!pause),
        .o_ce      (ce_cpu),
        .o_wrap    (w_cpu_wrap)
    );

    // Counts CPU wraps, so ce_psg lands on the same edge as every
    // PSG_DIV_X-th ce_cpu; it keeps counting through a pause.
    ce_div #(
        .DIV       (PSG_DIV_X)
    ) u_psg_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_div_clear),
        .i_advance (w_cpu_wrap),
        .i_gate    (!pause),
        .o_ce      (ce_psg),
        .o_wrap    (w_psg_wrap_unused)
    );

endmodule
`default_nettype wire

// File: tb/tb_sys_clkgen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_clkgen
//  Purpose  : Self-checking bench for sys_clkgen. A cycle model predicts
//             outputs from time-since-HOLD-entry; predictions are queued when
//             stimulus is applied and compared after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sys_clkgen;

    localparam int LW = 16;
    localparam int RH = 8;
    localparam int PD = 8;
    localparam int CD = 12;
    localparam int PX = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic pll_locked;
    logic reset_req;
    logic pause;
    logic sys_rst;
    logic ce_pix;
    logic ce_cpu;
    logic ce_psg;
    logic running;

    sys_clkgen #(
        .LOCK_WAIT  (LW),
        .RST_HOLD   (RH),
        .PIX_DIV    (PD),
        .CPU_DIV    (CD),
        .PSG_DIV_X  (PX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .reset_req  (reset_req),
        .pause      (pause),
        .sys_rst    (sys_rst),
        .ce_pix     (ce_pix),
        .ce_cpu     (ce_cpu),
        .ce_psg     (ce_psg),
        .running    (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sys_rst;
        logic ce_pix;
        logic ce_cpu;
        logic ce_psg;
        logic running;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    // model: 0 WAIT, 1 STAB, 2 HOLD, 3 RUN; m_t = edges since HOLD entry
    int   m_st, m_cnt, m_t;
    logic m_s1, m_s2;

    int last_pix, last_cpu, last_psg;
    int per_pix, per_cpu, per_psg;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d: observed %0b expected %0b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.sys_rst = 1'b1; e.ce_pix = 1'b0; e.ce_cpu = 1'b0;
        e.ce_psg  = 1'b0; e.running = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_t = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    // Predict the outputs after the coming clock edge from current inputs.
    task automatic model_edge();
        exp_t e;
        int   nx, ncnt;
        logic ls, act;
        if (!rst_n) begin
            model_reset();
            e = reset_exp();
        end else begin
            ls = m_s2; m_s2 = m_s1; m_s1 = pll_locked;
            nx = m_st; ncnt = m_cnt;
            case (m_st)
                0: begin ncnt = 0; if (ls) nx = 1; end
                1: if (!ls) begin nx = 0; ncnt = 0; end
                   else if (m_cnt == LW-1) begin nx = 2; ncnt = 0; end
                   else ncnt = m_cnt + 1;
                2: if (!ls) begin nx = 0; ncnt = 0; end
                   else if (reset_req) ncnt = 0;
                   else if (m_cnt == RH-1) begin nx = 3; ncnt = 0; end
                   else ncnt = m_cnt + 1;
                default: if (!ls) begin nx = 0; ncnt = 0; end
                   else if (reset_req) begin nx = 2; ncnt = 0; end
            endcase
            act = (nx >= 2);
            if (!act || (nx == 2 && m_st != 2)) m_t = 0;
            else m_t = m_t + 1;
            e.ce_pix  = act && (m_t != 0) && (m_t % PD == 0);
            e.ce_cpu  = act && (m_t != 0) && (m_t % CD == 0) && !pause;
            e.ce_psg  = act && (m_t != 0) && (m_t % (CD*PX) == 0) && !pause;
            e.sys_rst = (nx != 3);
            e.running = (nx == 3);
            m_st = nx; m_cnt = ncnt;
        end
        q.push_back(e);
    endtask

    task automatic compare_all(input exp_t e);
        chk("sys_rst", sys_rst, e.sys_rst);
        chk("ce_pix",  ce_pix,  e.ce_pix);
        chk("ce_cpu",  ce_cpu,  e.ce_cpu);
        chk("ce_psg",  ce_psg,  e.ce_psg);
        chk("running", running, e.running);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        edge_n++;
        #1;
        e = q.pop_front();
        compare_all(e);
        if (ce_pix === 1'b1) begin
            if (last_pix >= 0) per_pix = edge_n - last_pix;
            last_pix = edge_n;
        end
        if (ce_cpu === 1'b1) begin
            if (last_cpu >= 0) per_cpu = edge_n - last_cpu;
            last_cpu = edge_n;
        end
        if (ce_psg === 1'b1) begin
            if (last_psg >= 0) per_psg = edge_n - last_psg;
            last_psg = edge_n;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Raise the lock and measure (relative to the first sampling edge E0)
    // the edge of reset release, running rise and first ce_cpu.
    task automatic lock_and_measure(output int fall, output int run_e, output int first_cpu);
        int e0;
        fall = -1; run_e = -1; first_cpu = -1;
        pll_locked = 1'b1;
        e0 = edge_n + 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (fall < 0 && sys_rst === 1'b0) fall = edge_n - e0;
            if (run_e < 0 && running === 1'b1) run_e = edge_n - e0;
            if (first_cpu < 0 && ce_cpu === 1'b1) first_cpu = edge_n - e0;
        end
    endtask

    initial begin
        int fall, run_e, first_cpu, cnt_hi, n_cpu, e_drop, rise;
        exp_t e;
        last_pix = -1; last_cpu = -1; last_psg = -1;
        per_pix = 0; per_cpu = 0; per_psg = 0;
        rst_n = 1'b0; pll_locked = 1'b0; reset_req = 1'b0; pause = 1'b0;
        model_reset();

        // reset state, then idle in WAIT
        steps(3);
        #2 rst_n = 1'b1;
        steps(5);

        // first lock: reset released at E26, first ce_cpu at E30
        lock_and_measure(fall, run_e, first_cpu);
        chk_int("rst_fall_edge", fall, 2 + LW + RH);
        chk_int("running_edge", run_e, 2 + LW + RH);
        chk_int("first_cpu_edge", first_cpu, 2 + LW + CD);

        // soft reset pulse in RUN: exactly RH cycles of sys_rst
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        cnt_hi = (sys_rst === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sys_rst === 1'b1) cnt_hi++;
        end
        chk_int("soft_rst_len", cnt_hi, RH);

        // pause: no CPU/PSG enables while asserted
        pause = 1'b1;
        n_cpu = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ce_cpu === 1'b1 || ce_psg === 1'b1) n_cpu++;
        end
        chk_int("paused_cpu_psg", n_cpu, 0);
        pause = 1'b0;
        steps(40);

        // lock loss in RUN: sys_rst within 3 edges
        pll_locked = 1'b0;
        e_drop = edge_n + 1;
        rise = -1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rise < 0 && sys_rst === 1'b1) rise = edge_n - e_drop;
        end
        chk_int("lockloss_rst_edge", rise, 2);

        // one-cycle lock glitch during STAB restarts the full count
        pll_locked = 1'b1;
        steps(8);
        pll_locked = 1'b0;
        step();
        lock_and_measure(fall, run_e, first_cpu);
        chk_int("relock_fall_edge", fall, 2 + LW + RH);
        chk_int("relock_first_cpu", first_cpu, 2 + LW + CD);

        // async reset mid-HOLD
        pll_locked = 1'b0;
        steps(5);
        pll_locked = 1'b1;
        steps(22);
        chk_int("in_hold", m_st, 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        q.push_back(reset_exp());
        e = q.pop_front();
        compare_all(e);
        steps(3);
        #2 rst_n = 1'b1;

        // relock and measure steady-state enable periods
        last_pix = -1; last_cpu = -1; last_psg = -1;
        per_pix = 0; per_cpu = 0; per_psg = 0;
        steps(120);
        chk_int("pix_period", per_pix, PD);
        chk_int("cpu_period", per_cpu, CD);
        chk_int("psg_period", per_psg, CD * PX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
